// File: rtl/fir_avg_out_buffer_if.sv
// Stream bundle between the moving-sum adder, the averaging buffer and its consumer.
// master drives samples and out_ready; slave is the buffer itself.
interface fir_avg_out_buffer_if #(
   parameter int unsigned SIZE = 16
);
   logic [SIZE+1:0] sum_in;
   logic            in_valid;
   logic [SIZE-1:0] out_data;
   logic            out_valid;
   logic            out_ready;

   modport master (
      output sum_in,
      output in_valid,
      output out_ready,
      input  out_data,
      input  out_valid
   );

   modport slave (
      input  sum_in,
      input  in_valid,
      input  out_ready,
      output out_data,
      output out_valid
   );
endinterface

// File: rtl/fir_avg_out_buffer.sv
// Averaging output stage: drops pipeline warm-up samples, scales the 4-tap sum by 1/4 and
// buffers results in a FWFT FIFO. Define FIR_AVG_ROUND_EN to round half up instead of truncating.
module fir_avg_out_buffer #(
   parameter int unsigned SIZE   = 16,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned WARMUP = 5,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   fir_avg_out_buffer_if.slave      bus,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf,
   input  logic                     ovf_clr,
   output logic [CNT_W-1:0]         drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam logic [WW-1:0] WarmLast = WW'(WARMUP - 1);

   typedef enum logic [0:0] {StPrime, StRun} state_e;

   state_e          state_q, state_d;
   logic [WW-1:0]   warm_cnt_q, warm_cnt_d;

   logic [AW:0]     wr_ptr_q, rd_ptr_q;
   logic [SIZE-1:0] mem_q [DEPTH];
   logic [SIZE-1:0] hold_q;
   logic            ovf_q;
   logic [CNT_W-1:0] drop_cnt_q;

   logic [SIZE+2:0] sum_ext;
   logic [SIZE:0]   shifted;
   logic [SIZE-1:0] avg;
   logic            unused_lsb;

   logic empty, full, pop, push_req, push, drop;

   // ---------------- Scaling ----------------
`ifdef FIR_AVG_ROUND_EN
   assign sum_ext = {1'b0, bus.sum_in} + (SIZE+3)'(2);
`else
   assign sum_ext = {1'b0, bus.sum_in};
`endif
   assign shifted    = sum_ext[SIZE+2:2];
   assign unused_lsb = ^sum_ext[1:0];
   assign avg        = shifted[SIZE] ? '1 : shifted[SIZE-1:0];

   // ---------------- Warm-up FSM ----------------
   always_comb begin
      state_d    = state_q;
      warm_cnt_d = warm_cnt_q;
      unique case (state_q)
         StPrime: begin
            if (bus.in_valid) begin
               if (warm_cnt_q == WarmLast) begin
                  state_d = StRun;
               end else begin
                  warm_cnt_d = warm_cnt_q + WW'(1);
               end
            end
         end
         StRun:   state_d = StRun;
         default: state_d = StPrime;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StPrime;
         warm_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         warm_cnt_q <= warm_cnt_d;
      end
   end

   // ---------------- FIFO control ----------------
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop      = !empty && bus.out_ready;
   assign push_req = (state_q == StRun) && bus.in_valid;
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= avg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         hold_q   <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            hold_q   <= mem_q[rd_ptr_q[AW-1:0]];
         end
      end
   end

   // ---------------- Overflow reporting ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else if (drop) begin
         ovf_q <= 1'b1;
         if (ovf_clr) begin
            drop_cnt_q <= CNT_W'(1);
         end else if (drop_cnt_q != '1) begin
            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
         end
      end else if (ovf_clr) begin
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end
   end

   // ---------------- Outputs ----------------
   assign bus.out_valid = !empty;
   assign bus.out_data  = empty ? hold_q : mem_q[rd_ptr_q[AW-1:0]];
   assign level         = wr_ptr_q - rd_ptr_q;
   assign ovf           = ovf_q;
   assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_fir_avg_out_buffer.sv
// Scoreboard bench for fir_avg_out_buffer: a queue model of the FIFO plus warm-up and
// overflow state, with targeted constant checks for each scenario.
module tb_fir_avg_out_buffer;
   localparam int unsigned SIZE   = 16;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned WARMUP = 5;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned LW     = $clog2(DEPTH) + 1;
   localparam int          CMAX   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             ovf_clr;
   logic             ovf;
   logic [LW-1:0]    level;
   logic [CNT_W-1:0] drop_cnt;

   fir_avg_out_buffer_if #(.SIZE(SIZE)) bus ();

   fir_avg_out_buffer #(
      .SIZE   (SIZE),
      .DEPTH  (DEPTH),
      .WARMUP (WARMUP),
      .CNT_W  (CNT_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .level    (level),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   logic [SIZE-1:0] exp_q[$];
   bit  m_run;
   int  m_wcnt;
   bit  m_ovf;
   int  m_drop;
   int  n_cmp;
   int  n_err;

   function automatic logic [SIZE-1:0] avg_of(input logic [SIZE+1:0] s);
      longint v;
      v = longint'(s);
`ifdef FIR_AVG_ROUND_EN
      v = v + 2;
`endif
      v = v >> 2;
      if (v > ((longint'(1) << SIZE) - 1)) v = (longint'(1) << SIZE) - 1;
      return v[SIZE-1:0];
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      ovf_clr = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      m_run = 0;
      m_wcnt = 0;
      m_ovf = 0;
      m_drop = 0;
   endtask

   // One clock: scoreboard pop compare before the edge, state compare after it.
   task automatic cycle(input logic [SIZE+1:0] s, input bit vld, input bit rdy, input bit clr);
      bit pop, full;
      bus.sum_in = s;
      bus.in_valid = vld;
      bus.out_ready = rdy;
      ovf_clr = clr;
      pop = (exp_q.size() > 0) && rdy;
      full = (exp_q.size() == DEPTH);
      if (pop) begin
         n_cmp++;
         if (bus.out_data !== exp_q[0]) begin
            n_err++;
            $display("FAIL sb_data: got %h expected %h", bus.out_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
      end
      if (m_run && vld) begin
         if (!full || pop) exp_q.push_back(avg_of(s));
         else begin
            m_ovf = 1;
            m_drop = clr ? 1 : ((m_drop == CMAX) ? CMAX : m_drop + 1);
         end
      end else if (clr) begin
         m_ovf = 0;
         m_drop = 0;
      end
      if (!m_run && vld) begin
         if (m_wcnt == WARMUP - 1) m_run = 1;
         else m_wcnt++;
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (level !== LW'(exp_q.size())) begin
         n_err++;
         $display("FAIL sb_level: got %0d expected %0d", level, exp_q.size());
      end
      n_cmp++;
      if (bus.out_valid !== (exp_q.size() > 0)) begin
         n_err++;
         $display("FAIL sb_valid: got %b expected %b", bus.out_valid, exp_q.size() > 0);
      end
      n_cmp++;
      if (ovf !== m_ovf || drop_cnt !== CNT_W'(m_drop)) begin
         n_err++;
         $display("FAIL sb_ovf: got ovf=%b cnt=%0d expected ovf=%b cnt=%0d",
                  ovf, drop_cnt, m_ovf, m_drop);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 2 * DEPTH && exp_q.size() > 0; i++) cycle('0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL drain: got valid=%b left=%0d expected valid=0 left=0",
                  bus.out_valid, exp_q.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || level !== '0 || ovf !== 1'b0 ||
          drop_cnt !== '0) begin
         n_err++;
         $display("FAIL reset: got valid=%b data=%h level=%0d ovf=%b cnt=%0d expected all 0",
                  bus.out_valid, bus.out_data, level, ovf, drop_cnt);
      end
   endtask

   task automatic test_warmup();
      for (int i = 0; i < 6; i++) begin
         cycle(18'h00010, 1'b1, 1'b0, 1'b0);
         if (i < 5) begin
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
               n_err++;
               $display("FAIL warmup_discard[%0d]: got valid=%b expected 0", i, bus.out_valid);
            end
         end
      end
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0004 || level !== LW'(1)) begin
         n_err++;
         $display("FAIL warmup_first: got valid=%b data=%h level=%0d expected 1 0004 1",
                  bus.out_valid, bus.out_data, level);
      end
   endtask

   task automatic test_scaling();
      logic [SIZE-1:0] exp_a;
`ifdef FIR_AVG_ROUND_EN
      exp_a = 16'h0002;
`else
      exp_a = 16'h0001;
`endif
      cycle(18'h00006, 1'b1, 1'b0, 1'b0);
      cycle(18'h3FFFC, 1'b1, 1'b0, 1'b0);
      cycle('0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (bus.out_data !== exp_a) begin
         n_err++;
         $display("FAIL scale_small: got %h expected %h", bus.out_data, exp_a);
      end
      cycle('0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (bus.out_data !== 16'hFFFF) begin
         n_err++;
         $display("FAIL scale_max: got %h expected ffff", bus.out_data);
      end
      cycle('0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 16'hFFFF) begin
         n_err++;
         $display("FAIL hold_empty: got valid=%b data=%h expected 0 ffff",
                  bus.out_valid, bus.out_data);
      end
      cycle('0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 10; i++) cycle(18'(32'h100 + 4 * i), 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (level !== LW'(8) || ovf !== 1'b1 || drop_cnt !== CNT_W'(2) ||
          bus.out_data !== 16'h0040) begin
         n_err++;
         $display("FAIL overflow: got level=%0d ovf=%b cnt=%0d data=%h expected 8 1 2 0040",
                  level, ovf, drop_cnt, bus.out_data);
      end
      cycle('0, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (ovf !== 1'b0 || drop_cnt !== '0) begin
         n_err++;
         $display("FAIL ovf_clr: got ovf=%b cnt=%0d expected 0 0", ovf, drop_cnt);
      end
      cycle(18'h3FF, 1'b1, 1'b0, 1'b0);
      cycle(18'h3FF, 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if (ovf !== 1'b1 || drop_cnt !== CNT_W'(1)) begin
         n_err++;
         $display("FAIL clr_and_drop: got ovf=%b cnt=%0d expected 1 1", ovf, drop_cnt);
      end
      for (int i = 0; i < 260; i++) cycle(18'h3FF, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (drop_cnt !== CNT_W'(CMAX)) begin
         n_err++;
         $display("FAIL drop_sat: got %0d expected %0d", drop_cnt, CMAX);
      end
      cycle('0, 1'b0, 1'b0, 1'b1);
      drain();
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 8; i++) cycle(18'(32'h200 + 4 * i), 1'b1, 1'b0, 1'b0);
      cycle(18'h300, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (level !== LW'(8) || ovf !== 1'b0 || bus.out_data !== 16'h0081) begin
         n_err++;
         $display("FAIL full_push_pop: got level=%0d ovf=%b data=%h expected 8 0 0081",
                  level, ovf, bus.out_data);
      end
      drain();
   endtask

   task automatic test_throughput();
      for (int i = 0; i < 24; i++) begin
         cycle(18'(4 * i), 1'b1, 1'b1, 1'b0);
         n_cmp++;
         if (level > LW'(1) || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL throughput[%0d]: got level=%0d ovf=%b expected <=1 0", i, level, ovf);
         end
      end
      drain();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) cycle(18'(32'h1000 + 4 * i), 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (level !== LW'(5)) begin
         n_err++;
         $display("FAIL pre_reset_level: got %0d expected 5", level);
      end
      do_reset();
      n_cmp++;
      if (level !== '0 || bus.out_valid !== 1'b0 || ovf !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid: got level=%0d valid=%b ovf=%b expected 0 0 0",
                  level, bus.out_valid, ovf);
      end
      for (int i = 0; i < 6; i++) begin
         cycle(18'h00020, 1'b1, 1'b0, 1'b0);
         n_cmp++;
         if (bus.out_valid !== (i == 5)) begin
            n_err++;
            $display("FAIL rewarm[%0d]: got valid=%b expected %b", i, bus.out_valid, i == 5);
         end
      end
      drain();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      ovf_clr = 1'b0;
      bus.sum_in = '0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_warmup();
      test_scaling();
      test_overflow();
      test_full_push_pop();
      test_throughput();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fir_avg_out_buffer.md
Name: fir_avg_out_buffer

Overview:
- Downstream stage of the 4-tap moving-sum adder.
- Each cycle it takes the (SIZE+2)-bit registered sum, discards pipeline warm-up samples and scales by 1/4 to a SIZE-bit average.
- Results are buffered in a small synchronous FIFO and presented to the consumer over a valid/ready handshake.
- Reports overflow (dropped samples) with a sticky flag and a saturating drop counter.

Parameters:
- SIZE, 16, sample width; multiple of 4; sum_in is SIZE+2 bits.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- WARMUP, 5, number of accepted in_valid samples discarded after reset (upstream pipeline fill).
- CNT_W, 8, drop counter width.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- sum_in  input  SIZE+2  unsigned 4-tap sum from upstream
- in_valid  input  1  sum_in valid this cycle; tie high for free-running upstream
- out_data  output  SIZE  FIFO head, averaged sample
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head when out_valid && out_ready
- level  output  $clog2(DEPTH)+1  current FIFO occupancy
- ovf  output  1  sticky: a sample was dropped
- ovf_clr  input  1  clears ovf and drop_cnt
- drop_cnt  output  CNT_W  saturating count of dropped samples

Behaviour:
- One clock (clk). Synchronous active-high reset, sampled on the rising edge.
- Reset values:
  - out_valid=0, out_data=0, level=0, ovf=0, drop_cnt=0.
  - Warm-up counter=0; FIFO pointers=0.
- Warm-up FSM, states PRIME and RUN:
  - PRIME: each in_valid cycle increments warm_cnt; samples are not pushed.
  - When warm_cnt reaches WARMUP-1 with in_valid, the FSM moves to RUN; that sample is also discarded.
  - RUN: every in_valid sample is a push request. RUN is exited only by reset.
- Scaling (unsigned):
  - avg = sum_in >> 2 (truncate), result taken as SIZE bits.
  - Saturate to all-ones if the shifted value exceeds 2^SIZE-1 (guard; not reachable with legal upstream input).
- FIFO:
  - First-word-fall-through: out_data is the head whenever out_valid=1.
  - out_data holds its last value when empty.
  - Push is written on the rising edge and visible at out_valid the next cycle; latency from sum_in to out_valid is 1 cycle.
  - Pop when out_valid && out_ready; the head advances on the same edge.
- Boundary conditions:
  - Push and pop in the same cycle, not full: level unchanged, both accepted.
  - Full with simultaneous pop: push accepted (space freed same edge), no drop.
  - Full without pop: sample dropped, ovf<=1, drop_cnt increments and saturates at 2^CNT_W-1, FIFO contents unchanged.
  - Empty with out_ready=1: no pop, pointers unchanged.
  - ovf_clr and a new drop in the same cycle: ovf<=1 and drop_cnt<=1.
  - Pointers wrap modulo DEPTH. level is computed from extra-bit pointers (full = MSBs differ, low bits equal).
- Reset mid-operation: FIFO emptied, FSM returns to PRIME, counters cleared, ovf cleared. Data in flight is lost.
- in_valid=0: no state change except pops.

Optional Feature:
- Macro FIR_AVG_ROUND_EN.
- When defined: avg = (sum_in + 2) >> 2 (round half up), then saturate to 2^SIZE-1.
- When undefined: truncation as above.
- Saturation logic is present in both builds.

Test Plan:
- Warm-up: after reset, in_valid=1, sum_in=0x00010 for 6 cycles, out_ready=0.
  - -> out_valid stays 0 through cycle 5; after the 6th cycle out_valid=1, out_data=0x0004, level=1.
- Scaling/rounding: post warm-up, push sum_in=0x00006 then 0x3FFFC.
  - -> truncate build: 0x0001, 0xFFFF.
  - -> FIR_AVG_ROUND_EN build: 0x0002, 0xFFFF.
- Overflow: out_ready=0, push 10 samples post warm-up (DEPTH=8).
  - -> level=8, ovf=1, drop_cnt=2, out_data = first pushed value.
  - -> then ovf_clr pulse -> ovf=0, drop_cnt=0.
- Full with simultaneous push/pop: fill to 8, then out_ready=1 and in_valid=1 for one cycle.
  - -> level stays 8, ovf=0, head advances to entry 2.
- Throughput: out_ready=1 continuously, sum_in ramps 0x00000, 0x00004, 0x00008, ...
  - -> out_data ramps 0,1,2,... one per cycle, level<=1, no drops.
- Reset mid-operation: with level=5, assert reset 1 cycle.
  - -> next cycle level=0, out_valid=0, ovf=0; the next 5 valid samples are discarded again.
